// File: rtl/dark_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dark_bus_arbiter
//
// Shares one slave port between NM bus masters. An idle arbiter picks a
// winner at the clock edge (fixed priority or round robin), registers the
// one-hot grant and passes the owner's request through to the slave
// combinationally until the slave completes, the owner withdraws, or the
// optional wait timeout fires. Each grant is followed by exactly one idle
// cycle before the next arbitration.
//
// Ports
//   clk       in   1         clock, rising edge
//   res       in   1         asynchronous active-low reset
//   m_en      in   NM        per-master request, held until its m_valid
//   m_rw      in   NM        per-master direction, 1 = write
//   m_addr    in   NM*AW     per-master address, master i in slice i
//   m_wdata   in   NM*DW     per-master write data
//   m_be      in   NM*DW/8   per-master byte enables
//   m_valid   out  NM        per-master completion pulse
//   m_err     out  NM        per-master timeout flag (only with m_valid)
//   m_rdata   out  DW        shared read data, zero unless m_valid is set
//   s_en      out  1         slave request
//   s_rw      out  1         slave direction
//   s_addr    out  AW        slave address
//   s_wdata   out  DW        slave write data
//   s_be      out  DW/8      slave byte enables
//   s_valid   in   1         slave completion pulse
//   s_rdata   in   DW        slave read data
//   grant     out  NM        one-hot current owner, zero when idle
// ---------------------------------------------------------------------------
module dark_bus_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [NM-1:0]          m_en,
    input  logic [NM-1:0]          m_rw,
    input  logic [NM*AW-1:0]       m_addr,
    input  logic [NM*DW-1:0]       m_wdata,
    input  logic [NM*(DW/8)-1:0]   m_be,
    output logic [NM-1:0]          m_valid,
    output logic [NM-1:0]          m_err,
    output logic [DW-1:0]          m_rdata,
    output logic                   s_en,
    output logic                   s_rw,
    output logic [AW-1:0]          s_addr,
    output logic [DW-1:0]          s_wdata,
    output logic [DW/8-1:0]        s_be,
    input  logic                   s_valid,
    input  logic [DW-1:0]          s_rdata,
    output logic [NM-1:0]          grant
);

    localparam int BW     = DW / 8;
    localparam int IW     = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    // Round robin starts searching at (NM-1)+1 = 0, so master 0 wins first.
    localparam logic [IW-1:0] LAST_RST = IW'(NM - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [IW-1:0]   gidx_q,  gidx_d;   // binary index of the current owner
    logic [IW-1:0]   last_q,  last_d;   // most recent winner, for round robin
    logic [CW-1:0]   cnt_q,   cnt_d;    // slave wait cycles in this grant

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            g_en;
    logic            timeout_hit;

    // -----------------------------------------------------------------------
    // Winner selection. Both loops scan from the least preferred candidate
    // to the most preferred one so the last hit is the winner.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        if (MODE == 0) begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (m_en[i]) begin
                    win_found = 1'b1;
                    win_idx   = IW'(i);
                end
            end
        end else begin
            for (int k = NM; k >= 1; k--) begin
                if (m_en[(int'(last_q) + k) % NM]) begin
                    win_found = 1'b1;
                    win_idx   = IW'((int'(last_q) + k) % NM);
                end
            end
        end
    end

    assign g_en        = m_en[gidx_q];
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        m_valid = '0;
        m_err   = '0;
        m_rdata = '0;
        s_en    = 1'b0;
        s_rw    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_be    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_BUSY;
                    grant_d = NM'(1) << win_idx;
                    gidx_d  = win_idx;
                    last_d  = win_idx;
                    cnt_d   = '0;
                end
            end

            ST_BUSY: begin
                s_en    = g_en;
                s_rw    = m_rw[gidx_q];
                s_addr  = m_addr[gidx_q*AW +: AW];
                s_wdata = m_wdata[gidx_q*DW +: DW];
                s_be    = m_be[gidx_q*BW +: BW];

                // Slave completion outranks both abort and timeout.
                if (s_valid) begin
                    m_valid = grant_q;
                    m_rdata = s_rdata;
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (!g_en) begin
                    // Owner withdrew: s_en already follows m_en low, no reply.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (timeout_hit) begin
                    m_valid = grant_q;
                    m_err   = grant_q;
                    s_en    = 1'b0;
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant = grant_q;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dark_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dark_bus_arbiter
//
// Directed bench for dark_bus_arbiter. Two instances share clock and reset:
//   u_fix : NM=2, MODE=0 (fixed priority), TIMEOUT=4
//   u_rr  : NM=4, MODE=1 (round robin),   slave answers in the request cycle
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_dark_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic res;

    int checks;
    int errors;

    // ---------------- fixed-priority instance ----------------
    logic [1:0]       f_en, f_rw;
    logic [2*AW-1:0]  f_addr;
    logic [2*DW-1:0]  f_wdata;
    logic [7:0]       f_be;
    logic [1:0]       f_mvalid, f_merr, f_grant;
    logic [DW-1:0]    f_mrdata;
    logic             f_sen, f_srw;
    logic [AW-1:0]    f_saddr;
    logic [DW-1:0]    f_swdata;
    logic [3:0]       f_sbe;
    logic             f_svalid;
    logic [DW-1:0]    f_srdata;

    dark_bus_arbiter #(.NM(2), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(4)) u_fix (
        .clk     (clk),
        .res     (res),
        .m_en    (f_en),
        .m_rw    (f_rw),
        .m_addr  (f_addr),
        .m_wdata (f_wdata),
        .m_be    (f_be),
        .m_valid (f_mvalid),
        .m_err   (f_merr),
        .m_rdata (f_mrdata),
        .s_en    (f_sen),
        .s_rw    (f_srw),
        .s_addr  (f_saddr),
        .s_wdata (f_swdata),
        .s_be    (f_sbe),
        .s_valid (f_svalid),
        .s_rdata (f_srdata),
        .grant   (f_grant)
    );

    // ---------------- round-robin instance ----------------
    logic [3:0]       r_en, r_rw;
    logic [4*AW-1:0]  r_addr;
    logic [4*DW-1:0]  r_wdata;
    logic [15:0]      r_be;
    logic [3:0]       r_mvalid, r_merr, r_grant;
    logic [DW-1:0]    r_mrdata;
    logic             r_sen, r_srw;
    logic [AW-1:0]    r_saddr;
    logic [DW-1:0]    r_swdata;
    logic [3:0]       r_sbe;
    logic             r_svalid;
    logic [DW-1:0]    r_srdata;

    // Zero-wait slave: completes every request in the cycle it appears.
    assign r_svalid = r_sen;

    dark_bus_arbiter #(.NM(4), .AW(AW), .DW(DW), .MODE(1), .TIMEOUT(255)) u_rr (
        .clk     (clk),
        .res     (res),
        .m_en    (r_en),
        .m_rw    (r_rw),
        .m_addr  (r_addr),
        .m_wdata (r_wdata),
        .m_be    (r_be),
        .m_valid (r_mvalid),
        .m_err   (r_merr),
        .m_rdata (r_mrdata),
        .s_en    (r_sen),
        .s_rw    (r_srw),
        .s_addr  (r_saddr),
        .s_wdata (r_swdata),
        .s_be    (r_sbe),
        .s_valid (r_svalid),
        .s_rdata (r_srdata),
        .grant   (r_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #3;
        checks++;
        if (f_grant !== 2'b00 || f_sen !== 1'b0 || f_mvalid !== 2'b00 || f_merr !== 2'b00) begin
            errors++;
            $display("FAIL reset_fix: grant=%b s_en=%b m_valid=%b m_err=%b required 00/0/00/00",
                     f_grant, f_sen, f_mvalid, f_merr);
        end
        checks++;
        if (r_grant !== 4'b0000 || r_sen !== 1'b0 || r_mvalid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rr: grant=%b s_en=%b m_valid=%b required 0000/0/0000",
                     r_grant, r_sen, r_mvalid);
        end
        checks++;
        if (f_saddr !== '0 || f_swdata !== '0 || f_sbe !== '0 || f_srw !== 1'b0 || f_mrdata !== '0) begin
            errors++;
            $display("FAIL reset_sbus: s_addr=%h s_wdata=%h s_be=%h s_rw=%b m_rdata=%h required all zero",
                     f_saddr, f_swdata, f_sbe, f_srw, f_mrdata);
        end
        step();
        res = 1'b1;
    endtask

    // Both masters request together; slave answers 2 cycles after s_en rises.
    task automatic test_fixed_priority();
        f_en     = 2'b11;
        f_rw     = 2'b00;
        f_addr   = {32'h0000_2000, 32'h0000_1000};
        f_srdata = 32'hA5A5_0001;
        #1;
        checks++;
        if (f_grant !== 2'b00 || f_sen !== 1'b0) begin
            errors++;
            $display("FAIL fp_idle: grant=%b s_en=%b required 00/0", f_grant, f_sen);
        end
        step(); #1;                                  // BUSY cycle 1
        checks++;
        if (f_grant !== 2'b01 || f_sen !== 1'b1 || f_saddr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL fp_grant0: grant=%b s_en=%b s_addr=%h required 01/1/00001000",
                     f_grant, f_sen, f_saddr);
        end
        checks++;
        if (f_mvalid !== 2'b00) begin
            errors++;
            $display("FAIL fp_no_early_valid: m_valid=%b required 00", f_mvalid);
        end
        step();                                      // BUSY cycle 2
        step();                                      // BUSY cycle 3: slave replies
        f_svalid = 1'b1;
        #1;
        checks++;
        if (f_mvalid !== 2'b01 || f_merr !== 2'b00 || f_mrdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL fp_complete0: m_valid=%b m_err=%b m_rdata=%h required 01/00/a5a50001",
                     f_mvalid, f_merr, f_mrdata);
        end
        step();                                      // IDLE gap
        f_svalid = 1'b0;
        f_en     = 2'b10;
        #1;
        checks++;
        if (f_grant !== 2'b00 || f_sen !== 1'b0 || f_mvalid !== 2'b00 || f_mrdata !== '0) begin
            errors++;
            $display("FAIL fp_gap: grant=%b s_en=%b m_valid=%b m_rdata=%h required 00/0/00/0",
                     f_grant, f_sen, f_mvalid, f_mrdata);
        end
        step(); #1;
        checks++;
        if (f_grant !== 2'b10 || f_saddr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL fp_grant1: grant=%b s_addr=%h required 10/00002000", f_grant, f_saddr);
        end
        f_srdata = 32'h5A5A_0002;
        f_svalid = 1'b1;
        #1;
        checks++;
        if (f_mvalid !== 2'b10 || f_mrdata !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL fp_complete1: m_valid=%b m_rdata=%h required 10/5a5a0002", f_mvalid, f_mrdata);
        end
        step();
        f_svalid = 1'b0;
        f_en     = 2'b00;
        step();
    endtask

    task automatic test_write_passthrough();
        f_en    = 2'b10;
        f_rw    = 2'b10;
        f_addr  = {32'h0000_0100, 32'h0000_0FFC};
        f_wdata = {32'hDEAD_BEEF, 32'h1234_5678};
        f_be    = 8'hF3;
        step(); #1;
        checks++;
        if (f_sen !== 1'b1 || f_srw !== 1'b1 || f_saddr !== 32'h0000_0100 ||
            f_swdata !== 32'hDEAD_BEEF || f_sbe !== 4'hF) begin
            errors++;
            $display("FAIL wr_bus: s_en=%b s_rw=%b s_addr=%h s_wdata=%h s_be=%h required 1/1/00000100/deadbeef/f",
                     f_sen, f_srw, f_saddr, f_swdata, f_sbe);
        end
        step();
        f_svalid = 1'b1;
        #1;
        checks++;
        if (f_mvalid !== 2'b10 || f_merr !== 2'b00) begin
            errors++;
            $display("FAIL wr_valid: m_valid=%b m_err=%b required 10/00", f_mvalid, f_merr);
        end
        step();
        f_svalid = 1'b0;
        f_en     = 2'b00;
        f_rw     = 2'b00;
        #1;
        checks++;
        if (f_mvalid !== 2'b00 || f_grant !== 2'b00) begin
            errors++;
            $display("FAIL wr_single_pulse: m_valid=%b grant=%b required 00/00", f_mvalid, f_grant);
        end
        step();
    endtask

    task automatic test_abort();
        f_en = 2'b01;
        step(); #1;
        checks++;
        if (f_sen !== 1'b1) begin
            errors++;
            $display("FAIL abort_start: s_en=%b required 1", f_sen);
        end
        step();
        f_en = 2'b00;
        #1;
        checks++;
        if (f_sen !== 1'b0 || f_mvalid !== 2'b00) begin
            errors++;
            $display("FAIL abort_drop: s_en=%b m_valid=%b required 0/00", f_sen, f_mvalid);
        end
        step(); #1;
        checks++;
        if (f_grant !== 2'b00 || f_mvalid !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: grant=%b m_valid=%b required 00/00", f_grant, f_mvalid);
        end
        step();
    endtask

    // Slave silent: timeout on the 4th BUSY cycle.
    task automatic test_timeout();
        f_en = 2'b01;
        step(); step(); step(); #1;                  // BUSY cycle 3
        checks++;
        if (f_mvalid !== 2'b00 || f_sen !== 1'b1) begin
            errors++;
            $display("FAIL to_before: m_valid=%b s_en=%b required 00/1", f_mvalid, f_sen);
        end
        step(); #1;                                  // BUSY cycle 4
        checks++;
        if (f_mvalid !== 2'b01 || f_merr !== 2'b01 || f_sen !== 1'b0) begin
            errors++;
            $display("FAIL to_fire: m_valid=%b m_err=%b s_en=%b required 01/01/0",
                     f_mvalid, f_merr, f_sen);
        end
        step();
        f_en = 2'b00;
        #1;
        checks++;
        if (f_grant !== 2'b00 || f_mvalid !== 2'b00 || f_merr !== 2'b00) begin
            errors++;
            $display("FAIL to_idle: grant=%b m_valid=%b m_err=%b required 00/00/00",
                     f_grant, f_mvalid, f_merr);
        end
        step();
    endtask

    // Slave answers on exactly the timeout cycle: normal completion wins.
    task automatic test_timeout_coincide();
        f_en     = 2'b01;
        f_srdata = 32'h0BAD_F00D;
        step(); step(); step(); step();              // BUSY cycle 4
        f_svalid = 1'b1;
        #1;
        checks++;
        if (f_mvalid !== 2'b01 || f_merr !== 2'b00 || f_mrdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL to_coincide: m_valid=%b m_err=%b m_rdata=%h required 01/00/0badf00d",
                     f_mvalid, f_merr, f_mrdata);
        end
        step();
        f_svalid = 1'b0;
        f_en     = 2'b00;
        step();
    endtask

    task automatic test_reset_mid_busy();
        f_en = 2'b01;
        step(); #1;
        checks++;
        if (f_grant !== 2'b01) begin
            errors++;
            $display("FAIL rst_pre: grant=%b required 01", f_grant);
        end
        #2 res = 1'b0;
        #1;
        checks++;
        if (f_grant !== 2'b00 || f_sen !== 1'b0 || f_mvalid !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: grant=%b s_en=%b m_valid=%b required 00/0/00",
                     f_grant, f_sen, f_mvalid);
        end
        step();
        res = 1'b1;
        #1;
        checks++;
        if (f_grant !== 2'b00) begin
            errors++;
            $display("FAIL rst_hold: grant=%b required 00", f_grant);
        end
        step(); #1;
        checks++;
        if (f_grant !== 2'b01 || f_sen !== 1'b1) begin
            errors++;
            $display("FAIL rst_regrant: grant=%b s_en=%b required 01/1", f_grant, f_sen);
        end
        f_svalid = 1'b1;
        step();
        f_svalid = 1'b0;
        f_en     = 2'b00;
        step();
    endtask

    // All four masters request continuously: 0,1,2,3,0 with idle gaps.
    task automatic test_round_robin();
        logic [3:0] exp_g;
        r_en = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            exp_g = (k % 2 == 0) ? (4'b0001 << ((k / 2) % 4)) : 4'b0000;
            checks++;
            if (r_grant !== exp_g || r_mvalid !== exp_g) begin
                errors++;
                $display("FAIL rr_order step %0d: grant=%b m_valid=%b required %b/%b",
                         k, r_grant, r_mvalid, exp_g, exp_g);
            end
        end
        r_en = 4'b0000;
        step();
    endtask

    // ------------------------------------------------------------------
    initial begin
        checks   = 0;
        errors   = 0;
        res      = 1'b0;
        f_en     = '0; f_rw = '0; f_addr = '0; f_wdata = '0; f_be = '0;
        f_svalid = 1'b0; f_srdata = '0;
        r_en     = '0; r_rw = '0;
        r_addr   = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010, 32'h0000_0000};
        r_wdata  = '0; r_be = '1;
        r_srdata = 32'hCAFE_0000;

        test_reset();
        test_fixed_priority();
        test_write_passthrough();
        test_abort();
        test_timeout();
        test_timeout_coincide();
        test_reset_mid_busy();
        test_round_robin();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dark_bus_arbiter.md
DARK_BUS_ARBITER -- requirements
Module: dark_bus_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): NM, 2, number of bus masters (2..8).
REQ-002 SHALL have parameter AW, 32, address width.
REQ-003 SHALL have parameter DW, 32, data width; byte-enable width is DW/8.
REQ-004 SHALL have parameter MODE, 0, where 0 = fixed priority (lowest index wins) and 1 = round robin.
REQ-005 SHALL have parameter TIMEOUT, 255, max slave wait cycles; 0 disables the timeout.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports (name, direction, width, meaning): clk, in, 1, clock, rising edge.
REQ-008 res, in, 1, asynchronous active-low reset.
REQ-009 m_en, in, NM, per-master request, held high until that master's m_valid.
REQ-010 m_rw, in, NM, per-master direction, 1 = write.
REQ-011 m_addr, in, NM*AW, per-master address; master i occupies slice i.
REQ-012 m_wdata, in, NM*DW, per-master write data.
REQ-013 m_be, in, NM*DW/8, per-master byte enables.
REQ-014 m_valid, out, NM, per-master completion pulse.
REQ-015 m_err, out, NM, per-master timeout flag, asserted only together with m_valid.
REQ-016 m_rdata, out, DW, shared read data, qualified by m_valid.
REQ-017 s_en, s_rw, s_addr, s_wdata, s_be, out, 1/1/AW/DW/DW/8, slave-side request.
REQ-018 s_valid, in, 1, slave completion pulse; s_rdata, in, DW, slave read data.
REQ-019 grant, out, NM, one-hot current owner, all zero when idle.

Function
REQ-020 SHALL implement a two-state FSM, IDLE and BUSY.
REQ-021 In IDLE with any m_en high, SHALL select a winner at the clock edge, register grant, and enter BUSY; s_en rises 1 cycle after the request is seen.
REQ-022 MODE=0 SHALL select the lowest-index requesting master.
REQ-023 MODE=1 SHALL search from (last_grant+1) mod NM upward with wrap-around; last_grant updates on each grant and resets to NM-1, so master 0 wins first.
REQ-024 In BUSY, s_en = m_en[g] and s_rw/s_addr/s_wdata/s_be SHALL be the combinational copy of master g's slice.
REQ-025 In IDLE, s_en, s_rw, s_addr, s_wdata and s_be SHALL all be 0.
REQ-026 In BUSY, when s_valid=1, SHALL assert m_valid[g]=1 and m_rdata=s_rdata combinationally in the same cycle, then return to IDLE at the next edge.
REQ-027 m_rdata SHALL be 0 whenever no m_valid bit is high.
REQ-028 Outside completion cycles, m_valid and m_err SHALL be 0; no m_valid is ever asserted to a non-granted master.
REQ-029 Each master SHALL drop m_en at the edge ending its m_valid cycle, so the arbiter (back in IDLE) never re-grants a finished request.
REQ-030 Back-to-back grants SHALL have exactly one IDLE cycle between them.
REQ-031 Timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_valid.
REQ-032 When the counter equals TIMEOUT-1 with no s_valid (TIMEOUT>0), SHALL assert m_valid[g]=1 and m_err[g]=1 for one cycle, force s_en=0 that cycle, and return to IDLE.
REQ-033 If s_valid and the timeout coincide, the normal completion SHALL win and m_err stays 0.
REQ-034 Abort: if m_en[g] falls while BUSY without s_valid, SHALL drop s_en the same cycle, return to IDLE next edge, and give no m_valid.
REQ-035 Counter width SHALL be clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.
REQ-036 Requests from non-granted masters SHALL be ignored, with no effect on them, until the FSM is in IDLE.

Reset
REQ-037 res=0 SHALL immediately and asynchronously force IDLE, grant=0, counter=0, last_grant=NM-1, and all s_* and m_valid/m_err outputs to 0, including mid-transaction.
REQ-038 After res rises, the first arbitration SHALL occur at the first clock edge with any m_en high.

Verification
REQ-039 NM=2, MODE=0, m_en=11 simultaneously, slave responds 2 cycles after s_en -> master 0 is served first with m_valid[0] and m_rdata=s_rdata; then 1 IDLE cycle; then master 1 is granted.
REQ-040 NM=4, MODE=1, all m_en held continuously -> grant order 0,1,2,3,0 with one IDLE cycle between each.
REQ-041 TIMEOUT=4, slave never responds -> m_valid[g]=m_err[g]=1 on the 4th BUSY cycle, s_en=0 that cycle, then IDLE.
REQ-042 TIMEOUT=4, s_valid on the 4th BUSY cycle -> m_valid=1, m_err=0.
REQ-043 res pulled low during BUSY -> grant=0 and s_en=0 with no clock edge; after release, a pending m_en[0] gets grant=0001 at the next edge.
REQ-044 Write from master 1 with addr=0x100, wdata=0xDEADBEEF, be=0xF -> s_addr, s_wdata and s_be match exactly while s_en=1, and m_valid[1] pulses once.
